// File: rtl/pwm256_decode.sv
// pwm256_decode: recovers the per-frame duty value from a frame-aligned PWM waveform
module pwm256_decode #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic             locked,
  output logic             err_resync,
  output logic             sat
);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t state_q, state_d;
  logic pwm_s, pwm_q, rise, idle, mid, bnd;
  logic [WIDTH-1:0] pos_q, pos_d, d_out_q, d_out_d;
  logic [WIDTH:0] hicnt_q, hicnt_d;
  logic d_valid_q, d_valid_d, locked_q, locked_d, err_q, err_d, sat_q, sat_d;
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign pwm_s = pwm_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      always_comb sync_d = (sync_q << 1) | SYNC_STAGES'(pwm_in);
      always_ff @(posedge clk) sync_q <= rst ? '0 : sync_d;
      assign pwm_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      pwm_q     <= 1'b0;
      pos_q     <= '0;
      hicnt_q   <= '0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwm_q     <= pwm_s;
      pos_q     <= pos_d;
      hicnt_q   <= hicnt_d;
      d_out_q   <= d_out_d;
      d_valid_q <= d_valid_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      sat_q     <= sat_d;
    end
  end
  // A rising sample always becomes position 0, whether it opens the first frame or realigns one
  always_comb begin
    rise    = pwm_s & ~pwm_q;
    idle    = state_q == HUNT && !rise;
    mid     = state_q == LOCK && rise && pos_q != '0;
    bnd     = state_q == LOCK && pos_q == '0;
    state_d = idle ? HUNT : LOCK;
    pos_d   = idle ? '0 : mid ? WIDTH'(1) : pos_q + 1'b1;
    hicnt_d = idle ? '0 : (mid || pos_q == '0) ? (WIDTH+1)'(pwm_s) : hicnt_q + (WIDTH+1)'(pwm_s);
  end
  // hicnt never exceeds P, so its top bit alone marks a saturated frame
  always_comb begin
    d_valid_d = bnd;
    sat_d     = bnd & hicnt_q[WIDTH];
    err_d     = mid;
    d_out_d   = bnd ? (hicnt_q[WIDTH] ? '1 : hicnt_q[WIDTH-1:0]) : d_out_q;
    locked_d  = mid ? 1'b0 : bnd ? 1'b1 : locked_q;
  end
  assign d_out      = d_out_q;
  assign d_valid    = d_valid_q;
  assign locked     = locked_q;
  assign err_resync = err_q;
  assign sat        = sat_q;
endmodule

// File: tb/tb_pwm256_decode.sv
// tb_pwm256_decode: directed loopback bench driving pwm256_decode from a frame-latched generator model
module tb_pwm256_decode;
  logic clk, rst, pwm_in;
  logic [7:0] d_out;
  logic d_valid, locked, err_resync, sat;
  logic gen_on;
  logic [7:0] gen_cnt;
  logic [8:0] gen_duty, duty_req;
  int glitch_n, cyc, nerr, nval, ref_cyc, n_cmp, n_bad, e0, v0;

  pwm256_decode #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .d_out(d_out), .d_valid(d_valid),
    .locked(locked), .err_resync(err_resync), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Generator latches its duty at frame start, so a value of 256 holds the line high all frame
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (err_resync) nerr++;
    if (d_valid) nval++;
    gen_cnt++;
    if (gen_cnt == 8'd0) gen_duty = duty_req;
    pwm_in = gen_on && ((glitch_n > 0) || ({1'b0, gen_cnt} < gen_duty));
    if (glitch_n > 0) glitch_n--;
  endtask

  task automatic expect_strobe(input string tag, input int d, input int s, input int lk, input int gap);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      tick();
      got = d_valid;
    end
    check({tag, "_seen"}, int'(got), 1);
    if (got) begin
      check({tag, "_d"}, int'(d_out), d);
      check({tag, "_sat"}, int'(sat), s);
      check({tag, "_locked"}, int'(locked), lk);
      check({tag, "_gap"}, cyc - ref_cyc, gap);
    end
    ref_cyc = cyc;
  endtask

  task automatic change_duty(input int v);
    repeat (60) tick();
    duty_req = 9'(v);
  endtask

  initial begin
    rst = 1'b1; pwm_in = 1'b0; gen_on = 1'b0; gen_cnt = 8'd0; gen_duty = 9'd0; duty_req = 9'd0;
    glitch_n = 0; cyc = 0; nerr = 0; nval = 0; ref_cyc = 0; n_cmp = 0; n_bad = 0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_dout", int'(d_out), 0);
    check("rst_flags", int'({d_valid, locked, err_resync, sat}), 0);
    repeat (5) tick();
    check("hunt_low", int'({d_valid, locked, err_resync}), 0);
    gen_on = 1'b1; gen_cnt = 8'd255; duty_req = 9'd128;
    tick();
    ref_cyc = cyc;
    expect_strobe("lock128", 128, 0, 1, 259);
    expect_strobe("hold128", 128, 0, 1, 256);
    change_duty(10);
    expect_strobe("part128", 128, 0, 1, 256);
    expect_strobe("d10", 10, 0, 1, 256);
    change_duty(246);
    expect_strobe("part10", 10, 0, 1, 256);
    expect_strobe("d246", 246, 0, 1, 256);
    check("no_resync_dchg", nerr, 0);
    change_duty(0);
    expect_strobe("part246", 246, 0, 1, 256);
    expect_strobe("zero_a", 0, 0, 1, 256);
    expect_strobe("zero_b", 0, 0, 1, 256);
    change_duty(256);
    expect_strobe("part0", 0, 0, 1, 256);
    expect_strobe("sat_a", 255, 1, 1, 256);
    expect_strobe("sat_b", 255, 1, 1, 256);
    change_duty(10);
    expect_strobe("part_sat", 255, 1, 1, 256);
    expect_strobe("back10", 10, 0, 1, 256);
    check("no_resync_sat", nerr, 0);
    repeat (96) tick();
    e0 = nerr; v0 = nval; glitch_n = 3;
    tick();
    ref_cyc = cyc;
    repeat (8) tick();
    check("glitch_err", nerr - e0, 1);
    check("glitch_unlock", int'(locked), 0);
    // The generator's own edge lands mid-frame of the glitch alignment and pulls it back
    expect_strobe("realign", 10, 0, 1, 415);
    check("realign_err", nerr - e0, 2);
    check("dropped_frame", nval - v0, 1);
    expect_strobe("resume", 10, 0, 1, 256);
    repeat (56) tick();
    rst = 1'b1;
    tick();
    ref_cyc = cyc;
    rst = 1'b0;
    check("mid_rst_dout", int'(d_out), 0);
    check("mid_rst_flags", int'({d_valid, locked, err_resync, sat}), 0);
    expect_strobe("relock", 10, 0, 1, 455);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
